// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// Ports: byte_i/byte_valid_i/byte_ready_o form a valid/ready byte stream;
//        wr_en_o/wr_addr_o/wr_data_o form a single-cycle write strobe bus.
// The master modport is the loader's view; slave is the front-end/memory view.
interface imem_loader_if;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;

    modport master (
        input  byte_i,
        input  byte_valid_i,
        output byte_ready_o,
        output wr_en_o,
        output wr_addr_o,
        output wr_data_o
    );

    modport slave (
        output byte_i,
        output byte_valid_i,
        input  byte_ready_o,
        input  wr_en_o,
        input  wr_addr_o,
        input  wr_data_o
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words and writes
// them to consecutive instruction-memory words while holding the core stalled.
// Latency: 4 byte cycles + 1 write cycle per word; done_o pulses once after the last write.
// Backpressure: byte_ready_o is high only in LOAD; bytes offered in any other state wait.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   start_i, len_i       begin a load of len_i words (sampled only when idle)
//   bus (master)         byte stream in, instruction-memory write strobe out
//   busy_o, cpu_stall_o  high while loading or writing
//   done_o               one-cycle pulse after the final word is written
//   err_o                sticky flag: the most recent start carried an illegal length
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    imem_loader_if.master     bus,
    output logic              busy_o,
    output logic              cpu_stall_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    state_e              state_q,    state_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    // Only the first three bytes need storing; the fourth goes straight into
    // the output word register on its handshake.
    logic [23:0]         shift_q,    shift_d;
    logic [ADDR_W:0]     len_q,      len_d;
    logic                err_q,      err_d;
    // Write address/data are separate registers so they stay stable while the
    // next word is being assembled and hold their value between strobes.
    logic [31:0]         wr_addr_q,  wr_addr_d;
    logic [31:0]         wr_data_q,  wr_data_d;

    logic                byte_hs;
    logic                len_ok;
    logic                last_word;

    assign byte_hs   = (state_q == S_LOAD) && bus.byte_valid_i;
    assign len_ok    = (len_i != '0) && (len_i <= DEPTH_L);
    assign last_word = ({1'b0, word_idx_q} == (len_q - ONE_L));

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        err_d      = err_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_ok) begin
                        len_d      = len_i;
                        err_d      = 1'b0;
                        word_idx_d = '0;
                        byte_cnt_d = 2'd0;
                        shift_d    = '0;
                        state_d    = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (byte_hs) begin
                    unique case (byte_cnt_q)
                        2'd0: shift_d[7:0]   = bus.byte_i;
                        2'd1: shift_d[15:8]  = bus.byte_i;
                        2'd2: shift_d[23:16] = bus.byte_i;
                        2'd3: begin
                            // Fourth byte completes the word: capture it and
                            // its address together so both appear with wr_en_o.
                            wr_data_d = {bus.byte_i, shift_q};
                            wr_addr_d = {{(30 - ADDR_W){1'b0}}, word_idx_q, 2'b00};
                            shift_d   = '0;
                            state_d   = S_WRITE;
                        end
                        default: ;
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end

            S_WRITE: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                    state_d    = S_LOAD;
                end
            end

            S_DONE: begin
                word_idx_d = '0;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            word_idx_q <= '0;
            byte_cnt_q <= 2'd0;
            shift_q    <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            err_q      <= err_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    assign bus.byte_ready_o = (state_q == S_LOAD);
    assign bus.wr_en_o      = (state_q == S_WRITE);
    assign bus.wr_addr_o    = wr_addr_q;
    assign bus.wr_data_o    = wr_data_q;
    assign busy_o           = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign cpu_stall_o      = busy_o;
    assign done_o           = (state_q == S_DONE);
    assign err_o            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, single/multi-word loads, illegal
// lengths, ignored restart and a full-depth load.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_imem_loader;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              busy, stall, done, err;

    always #5 clk = ~clk;

    imem_loader_if ifc ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .len_i       (len),
        .bus         (ifc.master),
        .busy_o      (busy),
        .cpu_stall_o (stall),
        .done_o      (done),
        .err_o       (err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int  done_cnt;
    int  rdy_viol;
    int  stall_viol;
    bit  track;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor
    always @(negedge clk) begin
        if (ifc.wr_en_o) begin
            wa_q.push_back(ifc.wr_addr_o);
            wd_q.push_back(ifc.wr_data_o);
            if (ifc.byte_ready_o) rdy_viol++;
        end
        if (done) done_cnt++;
        if (track && !stall) stall_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        wa_q.delete();
        wd_q.delete();
        done_cnt   = 0;
        rdy_viol   = 0;
        stall_viol = 0;
    endtask

    // Start is consumed on the next rising edge; len is then scrambled to
    // show that later changes are ignored.
    task automatic do_start(input logic [ADDR_W:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start     = 1'b0;
        len       = '1;
        start_cyc = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        bit hs;
        t = 0;
        ifc.byte_i       = b;
        ifc.byte_valid_i = 1'b1;
        forever begin
            hs = ifc.byte_ready_o;
            @(negedge clk);
            if (hs) break;
            t++;
            if (t > 50) begin
                check("byte_handshake", 32'(hs), 32'd1);
                break;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            ifc.byte_valid_i = 1'b0;
            if (gap > 0) tick(gap);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] word_of(input int i);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4*i);
        b1 = 8'(4*i + 1);
        b2 = 8'(4*i + 2);
        b3 = 8'(4*i + 3);
        return {b3, b2, b1, b0};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst_n            = 1'b0;
        start            = 1'b0;
        len              = '0;
        ifc.byte_i       = 8'h00;
        ifc.byte_valid_i = 1'b0;
        track            = 1'b0;
        clr();

        // ---------------- reset state ----------------
        tick(2);
        check("rst_ready",  32'(ifc.byte_ready_o), 32'd0);
        check("rst_wr_en",  32'(ifc.wr_en_o),      32'd0);
        check("rst_addr",   ifc.wr_addr_o,         32'h0);
        check("rst_data",   ifc.wr_data_o,         32'h0);
        check("rst_busy",   32'(busy),             32'd0);
        check("rst_stall",  32'(stall),            32'd0);
        check("rst_done",   32'(done),             32'd0);
        check("rst_err",    32'(err),              32'd0);
        rst_n = 1'b1;
        tick(1);

        // ---------------- reset mid-load ----------------
        do_start(11'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        ifc.byte_i = 8'hCC;
        rst_n = 1'b0;
        tick(2);
        check("midrst_busy",  32'(busy),             32'd0);
        check("midrst_ready", 32'(ifc.byte_ready_o), 32'd0);
        check("midrst_wr_en", 32'(ifc.wr_en_o),      32'd0);
        check("midrst_data",  ifc.wr_data_o,         32'h0);
        rst_n = 1'b1;
        ifc.byte_valid_i = 1'b0;
        tick(6);
        check("midrst_no_write", 32'(wa_q.size()), 32'd0);
        check("midrst_idle",     32'(busy),        32'd0);

        // ---------------- single word ----------------
        clr();
        do_start(11'd1);
        check("w1_busy",  32'(busy),             32'd1);
        check("w1_ready", 32'(ifc.byte_ready_o), 32'd1);
        send_byte(8'h33);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h00);
        ifc.byte_valid_i = 1'b0;
        check("w1_wr_en",    32'(ifc.wr_en_o),      32'd1);
        check("w1_addr",     ifc.wr_addr_o,         32'h0);
        check("w1_data",     ifc.wr_data_o,         32'h00200033);
        check("w1_ready_wr", 32'(ifc.byte_ready_o), 32'd0);
        tick(1);
        check("w1_done",      32'(done),        32'd1);
        check("w1_done_busy", 32'(busy),        32'd0);
        check("w1_done_wren", 32'(ifc.wr_en_o), 32'd0);
        check("w1_data_hold", ifc.wr_data_o,    32'h00200033);
        // cycle index of done_o, counting the cycle entered at the start edge as 1
        check("w1_latency",   32'(cyc - start_cyc + 1), 32'd6);
        tick(1);
        check("w1_done_pulse", 32'(done), 32'd0);
        tick(1);
        check("w1_writes",   32'(wa_q.size()), 32'd1);
        check("w1_done_cnt", 32'(done_cnt),    32'd1);

        // ---------------- three words with gaps ----------------
        clr();
        do_start(11'd3);
        track = 1'b1;
        send_word(32'h002081B3, 2);
        send_word(32'h40208233, 1);
        send_word(32'h002092B3, 0);
        track = 1'b0;
        wait_done();
        tick(1);
        check("w3_writes", 32'(wa_q.size()), 32'd3);
        if (wa_q.size() == 3) begin
            check("w3_addr0", wa_q[0], 32'h0);
            check("w3_addr1", wa_q[1], 32'h4);
            check("w3_addr2", wa_q[2], 32'h8);
            check("w3_data0", wd_q[0], 32'h002081B3);
            check("w3_data1", wd_q[1], 32'h40208233);
            check("w3_data2", wd_q[2], 32'h002092B3);
        end
        check("w3_ready_on_write", 32'(rdy_viol),   32'd0);
        check("w3_stall_gaps",     32'(stall_viol), 32'd0);

        // ---------------- illegal lengths ----------------
        clr();
        do_start(11'd0);
        check("len0_err",  32'(err),  32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        tick(2);
        check("len0_idle", 32'(busy), 32'd0);
        do_start(11'(DEPTH + 1));
        check("lenbig_err",  32'(err),  32'd1);
        check("lenbig_busy", 32'(busy), 32'd0);
        do_start(11'd2);
        check("len2_err_clr", 32'(err),  32'd0);
        check("len2_busy",    32'(busy), 32'd1);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        wait_done();
        tick(1);
        check("len2_writes", 32'(wa_q.size()), 32'd2);

        // ---------------- start ignored during LOAD ----------------
        clr();
        do_start(11'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        ifc.byte_valid_i = 1'b0;
        start = 1'b1;
        len   = 11'd5;
        tick(1);
        start = 1'b0;
        send_byte(8'h33);
        send_byte(8'h44);
        ifc.byte_valid_i = 1'b0;
        send_word(32'hA5B6C7D8, 0);
        wait_done();
        tick(4);
        check("ign_writes", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("ign_data0", wd_q[0], 32'h44332211);
            check("ign_addr1", wa_q[1], 32'h4);
            check("ign_data1", wd_q[1], 32'hA5B6C7D8);
        end
        check("ign_idle", 32'(busy), 32'd0);

        // ---------------- full depth ----------------
        clr();
        do_start(11'(DEPTH));
        for (int i = 0; i < DEPTH; i++) send_word(word_of(i), 0);
        wait_done();
        tick(2);
        check("full_writes",   32'(wa_q.size()), 32'(DEPTH));
        check("full_done_cnt", 32'(done_cnt),    32'd1);
        if (wa_q.size() == DEPTH) begin
            check("full_last_addr", wa_q[DEPTH-1], 32'h00000FFC);
            check("full_last_data", wd_q[DEPTH-1], 32'hFFFEFDFC);
            bad = 0;
            for (int i = 0; i < DEPTH; i++)
                if (wa_q[i] !== 32'(4*i) || wd_q[i] !== word_of(i)) bad++;
            check("full_sequence", 32'(bad), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
